// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, mul/div FSM states and decode helpers for the EX-stage ALU
package alu_pkg;

  localparam logic [5:0] OP_SLL   = 6'h00;
  localparam logic [5:0] OP_SRL   = 6'h02;
  localparam logic [5:0] OP_SRA   = 6'h03;
  localparam logic [5:0] OP_MFHI  = 6'h10;
  localparam logic [5:0] OP_MTHI  = 6'h11;
  localparam logic [5:0] OP_MFLO  = 6'h12;
  localparam logic [5:0] OP_MTLO  = 6'h13;
  localparam logic [5:0] OP_MULT  = 6'h18;
  localparam logic [5:0] OP_MULTU = 6'h19;
  localparam logic [5:0] OP_DIV   = 6'h1A;
  localparam logic [5:0] OP_DIVU  = 6'h1B;
  localparam logic [5:0] OP_ADD   = 6'h20;
  localparam logic [5:0] OP_ADDU  = 6'h21;
  localparam logic [5:0] OP_SUB   = 6'h22;
  localparam logic [5:0] OP_SUBU  = 6'h23;
  localparam logic [5:0] OP_AND   = 6'h24;
  localparam logic [5:0] OP_OR    = 6'h25;
  localparam logic [5:0] OP_XOR   = 6'h26;
  localparam logic [5:0] OP_NOR   = 6'h27;
  localparam logic [5:0] OP_SLT   = 6'h2A;
  localparam logic [5:0] OP_SLTU  = 6'h2B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

  function automatic logic is_muldiv(input logic [5:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Within the mul/div group bit 1 selects divide and bit 0 selects the unsigned form.
  function automatic logic md_is_div(input logic [5:0] op);
    return op[1];
  endfunction

  function automatic logic md_is_signed(input logic [5:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative 32-step multiply/divide unit owning the HI/LO registers
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi_we,
  input  logic             mtlo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             idle,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(ITER);

  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             div_q, div_d;
  logic             neg_q, neg_d;
  logic             sa_q, sa_d;
  logic             bz_q, bz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0]   a_abs, b_abs, addend;
  logic [WIDTH:0]     mul_sum, div_sh;
  logic [2*WIDTH-1:0] prod, prod_fix;

  // acc holds the running product high half (mul) or partial remainder (div); mq the low half/quotient.
  assign a_abs    = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_abs    = (is_signed && b[WIDTH-1]) ? -b : b;
  assign addend   = mq_q[0] ? dvs_q : '0;
  assign mul_sum  = {1'b0, acc_q} + {1'b0, addend};
  assign div_sh   = {acc_q, mq_q[WIDTH-1]};
  assign prod     = {acc_q, mq_q};
  assign prod_fix = neg_q ? -prod : prod;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    dvs_d   = dvs_q;
    div_d   = div_q;
    neg_d   = neg_q;
    sa_d    = sa_q;
    bz_d    = bz_q;
    hi_d    = mthi_we ? wdata : hi_q;
    lo_d    = mtlo_we ? wdata : lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d   = '0;
          mq_d    = a_abs;
          dvs_d   = b_abs;
          div_d   = is_div;
          neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          sa_d    = is_signed & a[WIDTH-1];
          bz_d    = (b == '0);
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (div_q) begin
          if (div_sh >= {1'b0, dvs_q}) begin
            acc_d = div_sh[WIDTH-1:0] - dvs_q;
            mq_d  = {mq_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = div_sh[WIDTH-1:0];
            mq_d  = {mq_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          {acc_d, mq_d} = {mul_sum, mq_q[WIDTH-1:1]};
        end
        if (cnt_q == CW'(ITER - 1)) begin
          cnt_d   = '0;
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FIX: begin
        // Divide by zero leaves quotient all-ones and remainder |A|; re-signing the remainder restores A.
        if (div_q) begin
          lo_d = bz_q ? '1 : (neg_q ? -mq_q : mq_q);
          hi_d = sa_q ? -acc_q : acc_q;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      dvs_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      sa_q    <= 1'b0;
      bz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      dvs_q   <= dvs_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      sa_q    <= sa_d;
      bz_q    <= bz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == ST_BUSY);
  assign idle = (state_q == ST_IDLE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/alu_execute.sv
// rtl/alu_execute.sv - EX-stage ALU: combinational ops, HI/LO move muxing and mul/div stall decode
module alu_execute
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [5:0]       OpSel,
  input  logic [4:0]       shamt,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             stall
);

  logic [WIDTH-1:0] hi, lo, sum, diff;
  logic             md_op, md_start, md_busy, md_idle, mt_ok;

  assign md_op    = is_muldiv(OpSel);
  assign md_start = valid_in & md_op & md_idle;
  assign stall    = md_start | md_busy;
  assign mt_ok    = valid_in & ~stall;
  assign sum      = A + B;
  assign diff     = A - B;

  muldiv_iter #(
    .WIDTH(WIDTH),
    .ITER (ITER)
  ) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .start    (md_start),
    .is_signed(md_is_signed(OpSel)),
    .is_div   (md_is_div(OpSel)),
    .a        (A),
    .b        (B),
    .mthi_we  (mt_ok && (OpSel == OP_MTHI)),
    .mtlo_we  (mt_ok && (OpSel == OP_MTLO)),
    .wdata    (A),
    .busy     (md_busy),
    .idle     (md_idle),
    .hi       (hi),
    .lo       (lo)
  );

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (OpSel)
      OP_ADD: begin
        result   = sum;
        overflow = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_ADDU: result = sum;
      OP_SUB: begin
        result   = diff;
        overflow = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUBU: result = diff;
      OP_AND:  result = A & B;
      OP_OR:   result = A | B;
      OP_XOR:  result = A ^ B;
      OP_NOR:  result = ~(A | B);
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
      OP_SLTU: result = {{(WIDTH-1){1'b0}}, A < B};
      OP_SLL:  result = B << shamt;
      OP_SRL:  result = B >> shamt;
      OP_SRA:  result = WIDTH'($signed(B) >>> shamt);
      OP_MFHI: result = hi;
      OP_MFLO: result = lo;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule
